// File: rtl/adc_sample_packetizer.sv
// Groups a free-running ADC sample strobe into fixed-length packets, buffers whole packets
// and streams them out on ready/valid. Optional header word enabled by `PKT_HEADER_EN.
module adc_sample_packetizer #(
    parameter int unsigned DATA_W     = 32,
    parameter int unsigned PKT_LEN    = 100,
    parameter int unsigned FIFO_DEPTH = 512,
    parameter logic [15:0] MAGIC      = 16'hA55A
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              enable,
    input  logic [DATA_W-1:0] s_data,
    input  logic              s_valid,
    output logic [DATA_W-1:0] m_data,
    output logic              m_valid,
    output logic              m_last,
    input  logic              m_ready,
    output logic [31:0]       pkt_count,
    output logic [15:0]       drop_count,
    output logic              busy
);

`ifdef PKT_HEADER_EN
    localparam int unsigned W  = PKT_LEN + 1;
`else
    localparam int unsigned W  = PKT_LEN;
`endif
    localparam int unsigned AW = $clog2(FIFO_DEPTH);
    localparam int unsigned PW = AW + 1;
    localparam int unsigned CW = $clog2(PKT_LEN + 1);
    localparam int unsigned IW = $clog2(W + 1);
    localparam int unsigned KW = $clog2(FIFO_DEPTH / 2 + 2);

    typedef enum logic [1:0] {IDLE, ACCEPT, DISCARD} state_t;

    state_t            state;
    logic [CW-1:0]     in_cnt;
    logic [DATA_W-1:0] mem [FIFO_DEPTH];
    logic [PW-1:0]     wr_ptr;
    logic [PW-1:0]     rd_ptr;
    logic [PW-1:0]     wr_ptr_p1;
    logic [PW-1:0]     used;
    logic [KW-1:0]     committed_pkts;
    logic              in_flight;
    logic [IW-1:0]     out_idx;
    logic [DATA_W-1:0] hdr_word;
    logic              space_ok;
    logic              wr_en;
    logic              hdr_wr;
    logic              commit;
    logic              out_fire;
    logic              out_done;
    logic              adv;
    logic              mid_pkt;
    logic              load;

`ifdef PKT_HEADER_EN
    logic [15:0] seq;
    assign hdr_word = DATA_W'({MAGIC, seq});
    assign hdr_wr   = wr_en && (state == IDLE);
`else
    assign hdr_word = '0;
    assign hdr_wr   = 1'b0;
`endif

    // Admission only happens in IDLE, so no partially written packet holds space at that point.
    always_comb begin
        used      = wr_ptr - rd_ptr;
        wr_ptr_p1 = wr_ptr + PW'(1);
        space_ok  = (PW'(FIFO_DEPTH) - used) >= PW'(W);
        wr_en     = s_valid && (((state == IDLE) && enable && space_ok) || (state == ACCEPT));
        commit    = (state == ACCEPT) && s_valid && (in_cnt == CW'(PKT_LEN - 1));
        out_fire  = m_valid && m_ready;
        out_done  = out_fire && m_last;
        adv       = !m_valid || m_ready;
        mid_pkt   = out_idx != '0;
        load      = adv && (mid_pkt || (committed_pkts > KW'(in_flight)));
    end

    always_ff @(posedge clk) begin
        if (hdr_wr) begin
            mem[wr_ptr[AW-1:0]]    <= hdr_word;
            mem[wr_ptr_p1[AW-1:0]] <= s_data;
        end else if (wr_en) begin
            mem[wr_ptr[AW-1:0]] <= s_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= IDLE;
            in_cnt         <= '0;
            busy           <= 1'b0;
            drop_count     <= '0;
            wr_ptr         <= '0;
            rd_ptr         <= '0;
            committed_pkts <= '0;
            in_flight      <= 1'b0;
            out_idx        <= '0;
            m_data         <= '0;
            m_valid        <= 1'b0;
            m_last         <= 1'b0;
            pkt_count      <= '0;
`ifdef PKT_HEADER_EN
            seq            <= '0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (s_valid && enable) begin
                        in_cnt <= CW'(1);
                        busy   <= 1'b1;
                        if (space_ok) begin
                            state <= ACCEPT;
                        end else begin
                            state <= DISCARD;
                            if (drop_count != 16'hFFFF) drop_count <= drop_count + 16'd1;
                        end
                    end
                end
                ACCEPT, DISCARD: begin
                    if (s_valid) begin
                        if (in_cnt == CW'(PKT_LEN - 1)) begin
                            state  <= IDLE;
                            in_cnt <= '0;
                            busy   <= 1'b0;
                        end else begin
                            in_cnt <= in_cnt + CW'(1);
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase

`ifdef PKT_HEADER_EN
            if (hdr_wr) seq <= seq + 16'd1;
`endif
            if (wr_en) wr_ptr <= wr_ptr + (hdr_wr ? PW'(2) : PW'(1));

            committed_pkts <= committed_pkts + KW'(commit) - KW'(out_done);
            if (out_done) pkt_count <= pkt_count + 32'd1;

            // in_flight marks a started packet whose last word has not yet been accepted.
            if (load && !mid_pkt) in_flight <= 1'b1;
            else if (out_done)    in_flight <= 1'b0;

            if (load) begin
                m_data  <= mem[rd_ptr[AW-1:0]];
                m_valid <= 1'b1;
                m_last  <= out_idx == IW'(W - 1);
                rd_ptr  <= rd_ptr + PW'(1);
                out_idx <= (out_idx == IW'(W - 1)) ? '0 : out_idx + IW'(1);
            end else if (adv) begin
                m_valid <= 1'b0;
                m_last  <= 1'b0;
            end
        end
    end

    a_no_overflow: assert property (@(posedge clk) disable iff (rst)
        !(wr_en && (used == PW'(FIFO_DEPTH))));

endmodule

// File: tb/tb_adc_sample_packetizer.sv
// Scoreboard bench for adc_sample_packetizer (PKT_LEN=4, FIFO_DEPTH=16).
// Expectations follow `PKT_HEADER_EN when it is defined for the build.
module tb_adc_sample_packetizer;
    localparam int unsigned DATA_W     = 32;
    localparam int unsigned PKT_LEN    = 4;
    localparam int unsigned FIFO_DEPTH = 16;
`ifdef PKT_HEADER_EN
    localparam bit HDR = 1'b1;
`else
    localparam bit HDR = 1'b0;
`endif

    typedef struct packed {
        logic [31:0] data;
        logic        last;
    } exp_t;

    logic              clk;
    logic              rst;
    logic              enable;
    logic [DATA_W-1:0] s_data;
    logic              s_valid;
    logic [DATA_W-1:0] m_data;
    logic              m_valid;
    logic              m_last;
    logic              m_ready;
    logic [31:0]       pkt_count;
    logic [15:0]       drop_count;
    logic              busy;

    exp_t exp_q[$];
    int   n_checks;
    int   n_errors;
    int   ready_mode;
    bit   tog;

    adc_sample_packetizer #(
        .DATA_W(DATA_W), .PKT_LEN(PKT_LEN), .FIFO_DEPTH(FIFO_DEPTH), .MAGIC(16'hA55A)
    ) dut (
        .clk(clk), .rst(rst), .enable(enable), .s_data(s_data), .s_valid(s_valid),
        .m_data(m_data), .m_valid(m_valid), .m_last(m_last), .m_ready(m_ready),
        .pkt_count(pkt_count), .drop_count(drop_count), .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Downstream ready: 0 = always ready, 1 = alternating, 2 = stalled.
    always begin
        @(posedge clk);
        #1;
        tog = ~tog;
        case (ready_mode)
            0:       m_ready = 1'b1;
            1:       m_ready = tog;
            default: m_ready = 1'b0;
        endcase
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic push_pkt(input int first, input int seqv);
        exp_t e;
        if (HDR) begin
            e.data = {16'hA55A, 16'(seqv)};
            e.last = 1'b0;
            exp_q.push_back(e);
        end
        for (int i = 0; i < 4; i++) begin
            e.data = 32'(first + i);
            e.last = (i == 3);
            exp_q.push_back(e);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send(input int v);
        s_data  = 32'(v);
        s_valid = 1'b1;
        step(1);
    endtask

    task automatic idle();
        s_valid = 1'b0;
        s_data  = '0;
    endtask

    task automatic do_reset();
        rst    = 1'b1;
        enable = 1'b0;
        idle();
        step(3);
        rst = 1'b0;
        step(1);
    endtask

    task automatic wait_drain(input string name);
        int k;
        k = 0;
        while (exp_q.size() != 0 && k < 300) begin
            step(1);
            k++;
        end
        if (exp_q.size() != 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL %s_drain: got %0d words left expected 0", name, exp_q.size());
            exp_q.delete();
        end
        step(10);
    endtask

    // Pops the scoreboard on every handshake and checks that stalled words are held.
    task automatic monitor();
        logic        prev_stall;
        logic [31:0] prev_d;
        logic        prev_l;
        exp_t        e;
        prev_stall = 1'b0;
        prev_d     = '0;
        prev_l     = 1'b0;
        forever begin
            @(negedge clk);
            if (rst) begin
                prev_stall = 1'b0;
                continue;
            end
            if (prev_stall) begin
                check("stall_valid", 32'(m_valid), 32'd1);
                check("stall_data", m_data, prev_d);
                check("stall_last", 32'(m_last), 32'(prev_l));
            end
            if (m_valid && m_ready) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_errors++;
                    $display("FAIL unexpected_word: got %0h expected none", m_data);
                end else begin
                    e = exp_q.pop_front();
                    check("word_data", m_data, e.data);
                    check("word_last", 32'(m_last), 32'(e.last));
                end
            end
            prev_stall = m_valid && !m_ready;
            prev_d     = m_data;
            prev_l     = m_last;
        end
    endtask

    initial begin
        int npk;
        n_checks   = 0;
        n_errors   = 0;
        ready_mode = 0;
        rst        = 1'b1;
        enable     = 1'b1;
        s_valid    = 1'b0;
        s_data     = '0;
        fork
            monitor();
        join_none

        // Reset with the strobe toggling
        for (int i = 0; i < 3; i++) begin
            s_valid = (i % 2 == 0);
            s_data  = 32'(100 + i);
            step(1);
        end
        check("rst_m_valid", 32'(m_valid), 32'd0);
        check("rst_m_last", 32'(m_last), 32'd0);
        check("rst_m_data", m_data, 32'd0);
        check("rst_pkt_count", pkt_count, 32'd0);
        check("rst_drop_count", 32'(drop_count), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        rst    = 1'b0;
        enable = 1'b0;
        idle();
        for (int i = 0; i < 20; i++) begin
            step(1);
            check("idle_m_valid", 32'(m_valid), 32'd0);
        end

        // Basic streaming
        enable = 1'b1;
        push_pkt(1, 0);
        push_pkt(5, 1);
        for (int v = 1; v <= 8; v++) send(v);
        idle();
        wait_drain("basic");
        check("basic_pkt_count", pkt_count, 32'd2);
        check("basic_drop_count", 32'(drop_count), 32'd0);
        check("basic_busy", 32'(busy), 32'd0);

        // Alternating backpressure
        do_reset();
        ready_mode = 1;
        enable     = 1'b1;
        push_pkt(1, 0);
        push_pkt(5, 1);
        for (int v = 1; v <= 8; v++) send(v);
        idle();
        wait_drain("bp");
        check("bp_pkt_count", pkt_count, 32'd2);
        check("bp_drop_count", 32'(drop_count), 32'd0);

        // Overflow while stalled
        do_reset();
        ready_mode = 2;
        enable     = 1'b1;
        npk        = HDR ? 3 : 4;
        for (int p = 0; p < npk; p++) push_pkt(1 + 4 * p, p);
        for (int v = 1; v <= 24; v++) send(v);
        idle();
        step(3);
        check("ovf_drop_count", 32'(drop_count), HDR ? 32'd3 : 32'd2);
        check("ovf_m_valid", 32'(m_valid), 32'd1);
        check("ovf_first_word", m_data, HDR ? 32'hA55A0000 : 32'd1);
        check("ovf_pkt_count_stalled", pkt_count, 32'd0);
        ready_mode = 0;
        wait_drain("ovf");
        check("ovf_pkt_count", pkt_count, 32'(npk));

        // Enable dropped mid-packet
        do_reset();
        ready_mode = 0;
        enable     = 1'b1;
        push_pkt(1, 0);
        send(1);
        send(2);
        enable = 1'b0;
        send(3);
        check("en_busy_mid", 32'(busy), 32'd1);
        send(4);
        check("en_busy_after", 32'(busy), 32'd0);
        for (int v = 5; v <= 10; v++) send(v);
        idle();
        check("en_busy_ignored", 32'(busy), 32'd0);
        wait_drain("en");
        check("en_pkt_count", pkt_count, 32'd1);
        check("en_drop_count", 32'(drop_count), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/adc_sample_packetizer.md
Name: adc_sample_packetizer

Overview:
- Sits directly upstream of the UDP stream write port (wr_data/wr_valid/wr_last/wr_ready).
- Takes a free-running ADC sample strobe that cannot be stalled and groups the samples into fixed-length packets.
- Buffers whole packets in an internal FIFO and emits them on a ready/valid stream.
- Admission is packet-atomic: a packet is either accepted complete or dropped complete, so downstream never sees partial packets or mid-packet stalls from this block.

Parameters:
DATA_W, 32, sample and stream word width
PKT_LEN, 100, samples per packet (2..1024)
FIFO_DEPTH, 512, buffer words; power of 2; must be >= PKT_LEN (+1 with header)
MAGIC, 16'hA55A, header upper half (only used with PKT_HEADER_EN)

Ports:
clk  in  1  system clock (125 MHz domain)
rst  in  1  synchronous active-high reset
enable  in  1  start/stop packet capture
s_data  in  DATA_W  sample word
s_valid  in  1  sample strobe; no backpressure
m_data  out  DATA_W  stream word
m_valid  out  1  stream word valid
m_last  out  1  final word of packet
m_ready  in  1  downstream ready
pkt_count  out  32  packets emitted (m_last handshakes), wraps
drop_count  out  16  packets dropped, saturates at 16'hFFFF
busy  out  1  an input packet is in progress

Behaviour:
- Reset: m_valid=0, m_last=0, m_data=0, pkt_count=0, drop_count=0, busy=0; FIFO emptied; input FSM in IDLE. A reset mid-packet discards all buffered and partial data.
- Word count per packet: W = PKT_LEN, or PKT_LEN+1 with the header.
- Input FSM states:
  - IDLE: on s_valid && enable, check free space.
    - free >= W: go to ACCEPT, write the header word first if enabled, then write the sample.
    - Otherwise: go to DISCARD and increment drop_count (saturating).
    - This first sample counts as sample 1 of the packet in both cases.
  - ACCEPT: write each s_valid sample. When sample PKT_LEN is written, commit the packet (committed_pkts += 1) and return to IDLE.
  - DISCARD: count s_valid samples without writing. After sample PKT_LEN, return to IDLE.
- enable is sampled only in IDLE. Deasserting it mid-packet lets the current packet complete (or finish discarding); capture then stops.
- busy = state != IDLE.
- Header write and first sample write occur in the same cycle: the FIFO write port accepts 2 words/cycle only for this case; the implementation may instead pre-reserve a slot. Behaviour is defined only by the output word order.
- Output side:
  - Starts a packet only when committed_pkts > 0. Once started, m_valid stays high for all W words, gated only by m_ready.
  - m_valid rises <= 2 cycles after the commit cycle, given m_ready=1 and no packet in flight.
  - m_data, m_valid and m_last are registered and held stable while m_valid && !m_ready.
  - m_last is asserted with word W only.
  - On the m_last handshake: committed_pkts -= 1 and pkt_count += 1.
  - Back-to-back packets may follow with no idle cycle.
- Simultaneous commit and output packet completion in the same cycle: committed_pkts is unchanged (net 0).
- Free space counts words reserved by the packet in progress; the write side never overflows. A FIFO full flag with a write attempt is an assertion failure.
- Counter arithmetic is unsigned. committed_pkts is sized for FIFO_DEPTH/2+1.

Optional Feature:
PKT_HEADER_EN
- Defined: each packet is preceded by one header word {MAGIC[15:0], seq[15:0]}, zero-extended/truncated to DATA_W. seq starts at 0 after reset and increments per accepted packet; dropped packets do not consume a seq value. W = PKT_LEN+1.
- Undefined: no header, W = PKT_LEN, the MAGIC parameter is unused, and the first word of each packet is sample 1.

Test Plan (PKT_LEN=4, FIFO_DEPTH=16, header off unless stated):
1. Reset: assert rst 3 cycles with s_valid toggling -> all outputs 0, busy=0. Post-reset m_valid stays 0 for 20 idle cycles.
2. Basic: enable=1, m_ready=1, samples 1..8 on consecutive cycles -> stream 1,2,3,4(last),5,6,7,8(last); pkt_count=2, drop_count=0.
3. Backpressure: as test 2 with m_ready alternating 1/0 -> identical word sequence; m_data/m_last unchanged during every stalled cycle; no words lost or duplicated.
4. Overflow: m_ready=0, samples 1..24 -> 4 packets buffered, drop_count=2. Then m_ready=1 -> stream 1..16 with m_last on 4,8,12,16; pkt_count=4.
5. Enable mid-packet: enable=1, 2 samples (1,2), enable=0, samples 3..10 -> one packet 1,2,3,4(last); samples 5..10 ignored; busy falls after sample 4.
6. PKT_HEADER_EN defined, samples 1..8, m_ready=1 -> A55A0000,1,2,3,4(last),A55A0001,5,6,7,8(last). With m_ready=0 and 24 samples -> 3 packets buffered, drop_count=3.
